// File: rtl/riscv_multicycle_core.sv
// Multi-cycle RV32I-subset core: one shared ALU sequenced by a FETCH/DECODE/EXEC/MEM/WB FSM.
// Instruction memory is loaded through a write port; data memory and registers reset to index.
module riscv_multicycle_core #(
    parameter int unsigned     XLEN       = 32,
    parameter int unsigned     IMEM_DEPTH = 32,
    parameter int unsigned     DMEM_DEPTH = 128,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] i_imem_addr,
    input  logic [31:0]                   i_imem_wdata,
    output logic [XLEN-1:0]               o_pc,
    output logic [2:0]                    o_state,
    output logic [XLEN-1:0]               o_wb_data,
    output logic                          o_retire,
    output logic                          o_halted
);
    localparam int unsigned IW = $clog2(IMEM_DEPTH);
    localparam int unsigned DW = $clog2(DMEM_DEPTH);

    localparam logic [6:0]  OpReg    = 7'h33;
    localparam logic [6:0]  OpImm    = 7'h13;
    localparam logic [6:0]  OpLui    = 7'h37;
    localparam logic [6:0]  OpJal    = 7'h6f;
    localparam logic [6:0]  OpLoad   = 7'h03;
    localparam logic [6:0]  OpStore  = 7'h23;
    localparam logic [6:0]  OpBranch = 7'h63;
    localparam logic [31:0] Ecall    = 32'h0000_0073;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5
    } state_e;

    state_e          r_state, w_state_next;
    logic [XLEN-1:0] r_pc, r_a, r_b, r_imm, r_aluout, r_mdr, r_wb_data;
    logic [31:0]     r_ir;
    logic            r_retire;
    logic [31:0]     r_imem [IMEM_DEPTH];
    logic [XLEN-1:0] r_regs [32];
    logic [XLEN-1:0] r_dmem [DMEM_DEPTH];

    logic [6:0]      w_op, w_funct7;
    logic [4:0]      w_rd, w_rs1, w_rs2;
    logic [2:0]      w_funct3;
    logic            w_known, w_ecall, w_taken;
    logic [XLEN-1:0] w_imm, w_opb, w_alu, w_pc_plus4, w_wb_val;

    assign w_op       = r_ir[6:0];
    assign w_rd       = r_ir[11:7];
    assign w_funct3   = r_ir[14:12];
    assign w_rs1      = r_ir[19:15];
    assign w_rs2      = r_ir[24:20];
    assign w_funct7   = r_ir[31:25];
    assign w_ecall    = (r_ir == Ecall);
    assign w_known    = (w_op == OpReg) || (w_op == OpImm) || (w_op == OpLui) ||
                        (w_op == OpJal) || (w_op == OpLoad) || (w_op == OpStore) ||
                        (w_op == OpBranch);
    assign w_pc_plus4 = r_pc + XLEN'(4);
    assign w_taken    = ((w_funct3 == 3'b000) && (r_a == r_b)) ||
                        ((w_funct3 == 3'b001) && (r_a != r_b));
    assign w_wb_val   = (w_op == OpLoad) ? r_mdr : r_aluout;

    // Immediates are sign-extended to XLEN from the format's top bit
    always_comb begin
        w_imm = XLEN'($signed(r_ir[31:20]));
        case (w_op)
            OpStore:  w_imm = XLEN'($signed({r_ir[31:25], r_ir[11:7]}));
            OpBranch: w_imm = XLEN'($signed({r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0}));
            OpJal:    w_imm = XLEN'($signed({r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21],
                                             1'b0}));
            OpLui:    w_imm = XLEN'($signed({r_ir[31:12], 12'h000}));
            default:  ;
        endcase
    end

    always_comb begin
        w_opb = (w_op == OpReg) ? r_b : r_imm;
        w_alu = '0;
        if ((w_op == OpLoad) || (w_op == OpStore)) begin
            w_alu = r_a + r_imm;
        end else if (w_op == OpLui) begin
            w_alu = r_imm;
        end else if (w_op == OpJal) begin
            w_alu = w_pc_plus4;
        end else begin
            case (w_funct3)
                3'b000: w_alu = ((w_op == OpReg) && (w_funct7 == 7'b0100000)) ? r_a - w_opb
                                                                              : r_a + w_opb;
                3'b010: w_alu = XLEN'($signed(r_a) < $signed(w_opb));
                3'b110: w_alu = r_a | w_opb;
                3'b111: w_alu = r_a & w_opb;
                default: w_alu = '0;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StFetch:  w_state_next = StDecode;
            StDecode: begin
                if (w_ecall)       w_state_next = StHalt;
                else if (!w_known) w_state_next = StFetch;
                else               w_state_next = StExec;
            end
            StExec: begin
                if (w_op == OpBranch)                            w_state_next = StFetch;
                else if ((w_op == OpLoad) || (w_op == OpStore)) w_state_next = StMem;
                else                                             w_state_next = StWb;
            end
            StMem:    w_state_next = (w_op == OpLoad) ? StWb : StFetch;
            StWb:     w_state_next = StFetch;
            StHalt:   w_state_next = StHalt;
            default:  w_state_next = StFetch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= StFetch;
        else      r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (i_imem_we) r_imem[i_imem_addr] <= i_imem_wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc      <= RESET_PC;
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_imm     <= '0;
            r_aluout  <= '0;
            r_mdr     <= '0;
            r_wb_data <= '0;
            r_retire  <= 1'b0;
            for (int unsigned i = 0; i < 32; i++)         r_regs[i] <= XLEN'(i);
            for (int unsigned i = 0; i < DMEM_DEPTH; i++) r_dmem[i] <= XLEN'(i);
        end else begin
            // Every path back into FETCH completes an instruction
            r_retire <= (w_state_next == StFetch) && (r_state != StFetch);
            case (r_state)
                StFetch:  r_ir <= r_imem[r_pc[IW+1:2]];
                StDecode: begin
                    r_a   <= (w_rs1 == 5'd0) ? '0 : r_regs[w_rs1];
                    r_b   <= (w_rs2 == 5'd0) ? '0 : r_regs[w_rs2];
                    r_imm <= w_imm;
                    if (!w_known && !w_ecall) r_pc <= w_pc_plus4;
                end
                StExec: begin
                    r_aluout <= w_alu;
                    if (w_op == OpBranch)   r_pc <= w_taken ? r_pc + r_imm : w_pc_plus4;
                    else if (w_op == OpJal) r_pc <= r_pc + r_imm;
                end
                StMem: begin
                    if (w_op == OpLoad) begin
                        r_mdr <= r_dmem[r_aluout[DW+1:2]];
                    end else begin
                        r_dmem[r_aluout[DW+1:2]] <= r_b;
                        r_pc                     <= w_pc_plus4;
                    end
                end
                StWb: begin
                    r_wb_data <= w_wb_val;
                    if (w_rd != 5'd0)  r_regs[w_rd] <= w_wb_val;
                    if (w_op != OpJal) r_pc <= w_pc_plus4;
                end
                default: ;
            endcase
        end
    end

    assign o_pc      = r_pc;
    assign o_state   = r_state;
    assign o_wb_data = r_wb_data;
    assign o_retire  = r_retire;
    assign o_halted  = (r_state == StHalt);

endmodule

// File: tb/tb_riscv_multicycle_core.sv
// Bench for riscv_multicycle_core: directed programs plus random programs checked against an
// instruction-level ISA model; a second 64-bit, 8-word-IMEM instance checks parametrisation.
module tb_riscv_multicycle_core;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, imem_we;
    logic [4:0]  imem_addr;
    logic [31:0] imem_wdata, pc, wb_data;
    logic [2:0]  state;
    logic        retire, halted;

    riscv_multicycle_core u_dut (
        .clk(clk), .rst(rst), .i_imem_we(imem_we), .i_imem_addr(imem_addr),
        .i_imem_wdata(imem_wdata), .o_pc(pc), .o_state(state), .o_wb_data(wb_data),
        .o_retire(retire), .o_halted(halted)
    );

    logic        rst64, we64;
    logic [2:0]  addr64, state64;
    logic [31:0] wdata64;
    logic [63:0] pc64, wb64;
    logic        ret64, halt64;

    riscv_multicycle_core #(.XLEN(64), .IMEM_DEPTH(8)) u_dut64 (
        .clk(clk), .rst(rst64), .i_imem_we(we64), .i_imem_addr(addr64),
        .i_imem_wdata(wdata64), .o_pc(pc64), .o_state(state64), .o_wb_data(wb64),
        .o_retire(ret64), .o_halted(halt64)
    );

    int n_cmp = 0;
    int n_err = 0;

    // ISA-level model state
    logic [31:0] m_imem [32];
    logic [31:0] m_regs [32];
    logic [31:0] m_dmem [128];
    logic [31:0] m_pc, m_wb;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++)  m_regs[i] = 32'(i);
        for (int i = 0; i < 128; i++) m_dmem[i] = 32'(i);
        m_pc = 32'h0;
        m_wb = 32'h0;
    endtask

    function automatic logic [31:0] alu(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b, input logic sub);
        case (f3)
            3'd0:    return sub ? a - b : a + b;
            3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6:    return a | b;
            3'd7:    return a & b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step(output logic [31:0] e_pc, output logic [31:0] e_wb,
                              output int e_cyc);
        logic [31:0] ir, a, b, imm_i, imm_s, imm_b, imm_j, res, addr, nxt;
        logic        wr, taken;
        ir    = m_imem[m_pc[6:2]];
        a     = m_regs[ir[19:15]];
        b     = m_regs[ir[24:20]];
        imm_i = {{20{ir[31]}}, ir[31:20]};
        imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
        imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
        imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
        res   = 32'h0;
        wr    = 1'b0;
        e_cyc = 4;
        nxt   = m_pc + 32'd4;
        case (ir[6:0])
            7'h33: begin res = alu(ir[14:12], a, b, ir[31:25] == 7'h20); wr = 1'b1; end
            7'h13: begin res = alu(ir[14:12], a, imm_i, 1'b0); wr = 1'b1; end
            7'h37: begin res = {ir[31:12], 12'h000}; wr = 1'b1; end
            7'h6f: begin res = m_pc + 32'd4; nxt = m_pc + imm_j; wr = 1'b1; end
            7'h03: begin
                addr = a + imm_i;
                res = m_dmem[addr[8:2]];
                wr = 1'b1;
                e_cyc = 5;
            end
            7'h23: begin addr = a + imm_s; m_dmem[addr[8:2]] = b; end
            7'h63: begin
                e_cyc = 3;
                taken = (ir[14:12] == 3'd0) ? (a == b) : (a != b);
                if (taken) nxt = m_pc + imm_b;
            end
            default: e_cyc = 2;
        endcase
        if (wr) begin
            m_wb = res;
            if (ir[11:7] != 5'd0) m_regs[ir[11:7]] = res;
        end
        m_pc = nxt;
        e_pc = m_pc;
        e_wb = m_wb;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 32; i++) begin
            imem_we    = 1'b1;
            imem_addr  = 5'(i);
            imem_wdata = m_imem[i];
            @(negedge clk);
        end
        imem_we = 1'b0;
    endtask

    task automatic start_prog();
        rst = 1'b0;
        load_prog();
        @(negedge clk);
        model_reset();
        rst = 1'b1;
    endtask

    task automatic wait_retire(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!retire && cyc < 40);
    endtask

    task automatic step_cmp(input string tag, output logic [31:0] o_wb, output logic [31:0] o_pc);
        logic [31:0] e_pc, e_wb;
        int          e_cyc, cyc;
        model_step(e_pc, e_wb, e_cyc);
        wait_retire(cyc);
        check_eq({tag, ".cycles"}, 64'(cyc), 64'(e_cyc));
        check_eq({tag, ".pc"}, 64'(pc), 64'(e_pc));
        check_eq({tag, ".wb"}, 64'(wb_data), 64'(e_wb));
        o_wb = wb_data;
        o_pc = pc;
    endtask

    function automatic logic [31:0] gen_instr();
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] i12;
        logic [12:0] b13;
        logic [20:0] j21;
        logic [2:0]  pool [5];
        int          off;
        pool = '{3'b010, 3'b110, 3'b111, 3'b001, 3'b100};
        rd   = 5'($urandom);
        rs1  = 5'($urandom);
        rs2  = 5'($urandom);
        i12  = 12'($urandom);
        case ($urandom_range(0, 11))
            0, 1:    return {i12, rs1, 3'b000, rd, 7'h13};
            2:       return {i12, rs1, pool[$urandom_range(0, 4)], rd, 7'h13};
            3, 4:    return {($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, rs2, rs1, 3'b000, rd,
                             7'h33};
            5:       return {7'h00, rs2, rs1, pool[$urandom_range(0, 4)], rd, 7'h33};
            6:       return {20'($urandom), rd, 7'h37};
            7:       return {i12, rs1, 3'b010, rd, 7'h03};
            8:       return {i12[11:5], rs2, rs1, 3'b010, i12[4:0], 7'h23};
            9: begin
                off = (int'($urandom_range(0, 8)) - 4) * 4;
                b13 = off[12:0];
                return {b13[12], b13[10:5], rs2, rs1, 2'b00, 1'($urandom), b13[4:1], b13[11],
                        7'h63};
            end
            10: begin
                off = (int'($urandom_range(0, 8)) - 4) * 4;
                j21 = off[20:0];
                return {j21[20], j21[10:1], j21[11], j21[19:12], rd, 7'h6f};
            end
            default: return {25'($urandom), 7'h0b};
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] w, p;
        int          cyc, rc;
        rst = 1'b0; imem_we = 1'b0; imem_addr = '0; imem_wdata = '0;
        rst64 = 1'b0; we64 = 1'b0; addr64 = '0; wdata64 = '0;
        @(negedge clk);

        // Simple ALU pair
        for (int i = 0; i < 32; i++) m_imem[i] = 32'h0;
        m_imem[0] = 32'h00500113;
        m_imem[1] = 32'h00210233;
        start_prog();
        step_cmp("t1.addi", w, p);
        check_eq("t1.addi_wb5", 64'(w), 64'd5);
        step_cmp("t1.add", w, p);
        check_eq("t1.add_wb10", 64'(w), 64'd10);
        check_eq("t1.add_pc8", 64'(p), 64'd8);

        // Memory, branches, x0, slt, then ecall
        for (int i = 0; i < 32; i++) m_imem[i] = 32'h0;
        m_imem[0] = 32'h00202423;  // sw x2,8(x0)
        m_imem[1] = 32'h00802303;  // lw x6,8(x0)
        m_imem[2] = 32'h00210463;  // beq x2,x2,+8
        m_imem[4] = 32'h00211463;  // bne x2,x2,+8
        m_imem[5] = 32'h00700013;  // addi x0,x0,7
        m_imem[6] = 32'h000003B3;  // add x7,x0,x0
        m_imem[7] = 32'hFFF00093;  // addi x1,x0,-1
        m_imem[8] = 32'h0020A1B3;  // slt x3,x1,x2
        m_imem[9] = 32'h00000073;  // ecall
        start_prog();
        step_cmp("t2.sw", w, p);
        step_cmp("t2.lw", w, p);
        check_eq("t2.lw_wb2", 64'(w), 64'd2);
        step_cmp("t3.beq", w, p);
        check_eq("t3.beq_pc", 64'(p), 64'd16);
        step_cmp("t3.bne", w, p);
        check_eq("t3.bne_pc", 64'(p), 64'd20);
        step_cmp("t4.addi_x0", w, p);
        check_eq("t4.x0_wb7", 64'(w), 64'd7);
        step_cmp("t4.read_x0", w, p);
        check_eq("t4.x0_reads0", 64'(w), 64'd0);
        step_cmp("t4.addi_m1", w, p);
        step_cmp("t4.slt", w, p);
        check_eq("t4.slt_wb1", 64'(w), 64'd1);
        cyc = 0;
        while (!halted && cyc < 10) begin @(negedge clk); cyc++; end
        check_eq("t5.halted", 64'(halted), 64'd1);
        check_eq("t5.state", 64'(state), 64'd5);
        rc = 0;
        repeat (20) begin @(negedge clk); if (retire) rc++; end
        check_eq("t5.halt_retires", 64'(rc), 64'd0);
        check_eq("t5.halt_pc", 64'(pc), 64'd36);
        check_eq("t5.halt_sticky", 64'(halted), 64'd1);

        // Reset in the middle of a load
        for (int i = 0; i < 32; i++) m_imem[i] = 32'h0;
        m_imem[0] = 32'h00500093;  // addi x1,x0,5
        m_imem[1] = 32'h00802303;  // lw x6,8(x0)
        start_prog();
        step_cmp("t5.pre_addi", w, p);
        cyc = 0;
        while (state != 3'd3 && cyc < 20) begin @(negedge clk); cyc++; end
        check_eq("t5.reach_mem", 64'(state), 64'd3);
        rst = 1'b0;
        @(negedge clk);
        check_eq("t5.rst_pc", 64'(pc), 64'd0);
        check_eq("t5.rst_state", 64'(state), 64'd0);
        check_eq("t5.rst_wb", 64'(wb_data), 64'd0);
        check_eq("t5.rst_retire", 64'(retire), 64'd0);
        check_eq("t5.rst_halted", 64'(halted), 64'd0);
        model_reset();
        rst = 1'b1;
        step_cmp("t5.post_addi", w, p);
        step_cmp("t5.post_lw", w, p);
        check_eq("t5.post_lw_wb2", 64'(w), 64'd2);

        // Random programs against the ISA model
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 32; i++) m_imem[i] = gen_instr();
            start_prog();
            for (int s = 0; s < 48; s++) step_cmp($sformatf("rnd%0d.%0d", r, s), w, p);
        end

        // 64-bit datapath with an 8-word IMEM: pc 32 fetches word 0 again
        for (int i = 0; i < 8; i++) begin
            we64    = 1'b1;
            addr64  = 3'(i);
            wdata64 = (i == 0) ? 32'hFFF00293 : 32'h00130313;
            @(negedge clk);
        end
        we64 = 1'b0;
        @(negedge clk);
        rst64 = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            cyc = 0;
            do begin @(negedge clk); cyc++; end while (!ret64 && cyc < 40);
            check_eq($sformatf("t6.cycles%0d", k), 64'(cyc), 64'd4);
            if (k == 1) check_eq("t6.addi_m1", wb64, 64'hFFFF_FFFF_FFFF_FFFF);
            if (k == 8) begin
                check_eq("t6.pc32", pc64, 64'd32);
                check_eq("t6.count13", wb64, 64'd13);
            end
            if (k == 9) begin
                check_eq("t6.wrap_wb", wb64, 64'hFFFF_FFFF_FFFF_FFFF);
                check_eq("t6.wrap_pc", pc64, 64'd36);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
